spi_bus_bridge: RTL and testbench

//  SPI mode-0 slave that turns AVR SPI frames into single parallel bus cycles
//  (addr/data/rw/sel_n) for the FDC register/flash core downstream.
//  All SPI inputs are synchronised to clock_50; one 3-byte frame = one bus cycle.

---
 rtl/spi_bus_bridge.sv | 208 ++++++++++++++++++++
 tb/tb_spi_bus_bridge.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_bus_bridge.sv
// SPI mode-0 slave: turns 3-byte AVR frames into single parallel bus cycles.
// SPI inputs are resynchronised to clock_50; all bus outputs are registered.
module spi_bus_bridge #(
  parameter int unsigned SEL_TICKS = 12
) (
  input  logic        clock_50,
  input  logic        reset_n,
  input  logic        spi_sck,
  input  logic        spi_ss_n,
  input  logic        spi_mosi,
  output logic        spi_miso,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_wdata_oe,
  input  logic [7:0]  bus_rdata,
  output logic        bus_rw,
  output logic        bus_sel_n,
  output logic        frame_err
);
  localparam int unsigned TickW = $clog2(SEL_TICKS + 1);
  localparam logic [TickW-1:0] LastTick = TickW'(SEL_TICKS - 1);

  typedef enum logic [2:0] {StIdle, StCmd, StAddr, StBusRd, StData, StBusWr, StDone} state_e;

  logic [2:0] sck_sync;
  logic [1:0] ss_sync, mosi_sync;
  logic       ss, mosi, sck_rise, sck_fall;

  logic [7:0] rx_q, rx_next;
  logic [2:0] bit_cnt_q;
  logic [1:0] byte_cnt_q;
  logic       byte_done, mid_frame;

  state_e           state_q, state_d;
  logic [15:0]      addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d, tx_q, tx_d;
  logic             rw_q, rw_d, sel_n_q, sel_n_d, oe_q, oe_d;
  logic             abort_q, abort_d, err_q, err_d;
  logic [TickW-1:0] tick_q, tick_d;

  assign ss        = ss_sync[1];
  assign mosi      = mosi_sync[1];
  assign sck_rise  = sck_sync[1] & ~sck_sync[2];
  assign sck_fall  = ~sck_sync[1] & sck_sync[2];
  assign rx_next   = {rx_q[6:0], mosi};
  assign byte_done = sck_rise && (bit_cnt_q == 3'd7);
  assign mid_frame = (byte_cnt_q == 2'd1) || (byte_cnt_q == 2'd2);

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      sck_sync  <= 3'b000;
      ss_sync   <= 2'b11;
      mosi_sync <= 2'b00;
    end else begin
      sck_sync  <= {sck_sync[1:0], spi_sck};
      ss_sync   <= {ss_sync[0], spi_ss_n};
      mosi_sync <= {mosi_sync[0], spi_mosi};
    end
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      rx_q       <= 8'h00;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
    end else if (ss) begin
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 2'd0;
    end else if (sck_rise) begin
      rx_q      <= rx_next;
      bit_cnt_q <= bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7 && byte_cnt_q != 2'd3) byte_cnt_q <= byte_cnt_q + 2'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rw_d    = rw_q;
    sel_n_d = sel_n_q;
    oe_d    = oe_q;
    tick_d  = tick_q;
    abort_d = abort_q;
    err_d   = 1'b0;
    tx_d    = tx_q;
    if (ss) tx_d = 8'h00;
    else if (sck_fall) tx_d = {tx_q[6:0], 1'b0};

    unique case (state_q)
      StIdle: begin
        abort_d = 1'b0;
        if (!ss) state_d = StCmd;
      end
      StCmd: begin
        if (ss) begin
          state_d = StIdle;
          err_d   = mid_frame;
        end else if (byte_done) begin
          rw_d          = rx_next[7];
          addr_d[15:8]  = {1'b0, rx_next[6:0]};
          state_d       = StAddr;
        end
      end
      StAddr: begin
        if (ss) begin
          state_d = StIdle;
          err_d   = mid_frame;
        end else if (byte_done) begin
          addr_d[7:0] = rx_next;
          if (rw_q) begin
            sel_n_d = 1'b0;
            tick_d  = '0;
            state_d = StBusRd;
          end else begin
            state_d = StData;
          end
        end
      end
      StBusRd: begin
        // A deselect mid-cycle is remembered; the strobe still runs its full length.
        if (ss) abort_d = 1'b1;
        tick_d = tick_q + TickW'(1);
        if (tick_q == LastTick) begin
          sel_n_d = 1'b1;
          tick_d  = '0;
          if (abort_q || ss) begin
            state_d = StIdle;
            err_d   = 1'b1;
            tx_d    = 8'h00;
          end else begin
            tx_d    = bus_rdata;
            state_d = StData;
          end
        end
      end
      StData: begin
        if (ss) begin
          state_d = StIdle;
          err_d   = mid_frame;
        end else if (byte_done) begin
          if (rw_q) begin
            state_d = StDone;
          end else begin
            wdata_d = rx_next;
            sel_n_d = 1'b0;
            oe_d    = 1'b1;
            tick_d  = '0;
            state_d = StBusWr;
          end
        end
      end
      StBusWr: begin
        if (ss) abort_d = 1'b1;
        if (sel_n_q) begin
          // Strobe already released last cycle: drop the data driver now for hold time.
          oe_d    = 1'b0;
          state_d = (abort_q || ss) ? StIdle : StDone;
        end else begin
          tick_d = tick_q + TickW'(1);
          if (tick_q == LastTick) begin
            sel_n_d = 1'b1;
            tick_d  = '0;
          end
        end
      end
      StDone: begin
        if (ss) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      addr_q  <= 16'h0000;
      wdata_q <= 8'h00;
      rw_q    <= 1'b1;
      sel_n_q <= 1'b1;
      oe_q    <= 1'b0;
      tick_q  <= '0;
      abort_q <= 1'b0;
      err_q   <= 1'b0;
      tx_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rw_q    <= rw_d;
      sel_n_q <= sel_n_d;
      oe_q    <= oe_d;
      tick_q  <= tick_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      tx_q    <= tx_d;
    end
  end

  assign bus_addr     = addr_q;
  assign bus_wdata    = wdata_q;
  assign bus_rw       = rw_q;
  assign bus_sel_n    = sel_n_q;
  assign bus_wdata_oe = oe_q;
  assign frame_err    = err_q;
  assign spi_miso     = spi_ss_n ? 1'bz : ((state_q == StDone) ? 1'b0 : tx_q[7]);

endmodule

// File: tb/tb_spi_bus_bridge.sv
// Self-checking bench for spi_bus_bridge: expected bus cycles are queued when a
// frame is sent and compared by a monitor when the strobe pulse completes.
module tb_spi_bus_bridge;
  localparam int SelTicks = 12;
  localparam int Half     = 120;

  logic        clock_50 = 1'b0;
  logic        reset_n, spi_sck, spi_ss_n, spi_mosi;
  wire         spi_miso;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata, bus_rdata;
  logic        bus_wdata_oe, bus_rw, bus_sel_n, frame_err;

  typedef struct {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  wdata;
    bit          full;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0, n_pass = 0, n_pulses = 0, fe_samples = 0;

  spi_bus_bridge #(.SEL_TICKS(SelTicks)) dut (
    .clock_50    (clock_50),
    .reset_n     (reset_n),
    .spi_sck     (spi_sck),
    .spi_ss_n    (spi_ss_n),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .bus_addr    (bus_addr),
    .bus_wdata   (bus_wdata),
    .bus_wdata_oe(bus_wdata_oe),
    .bus_rdata   (bus_rdata),
    .bus_rw      (bus_rw),
    .bus_sel_n   (bus_sel_n),
    .frame_err   (frame_err)
  );

  always #10 clock_50 = ~clock_50;

  // Bus monitor: measures each strobe pulse and compares it against the scoreboard.
  initial begin
    bit          in_pulse = 1'b0, oe_all, oe_any, cap_rw;
    int          len;
    logic [15:0] cap_addr;
    logic [7:0]  cap_wdata;
    exp_t        cur;
    forever begin
      @(negedge clock_50);
      if (frame_err === 1'b1) fe_samples++;
      if (bus_sel_n === 1'b0) begin
        if (!in_pulse) begin
          in_pulse  = 1'b1;
          len       = 0;
          oe_all    = 1'b1;
          oe_any    = 1'b0;
          cap_addr  = bus_addr;
          cap_rw    = bus_rw;
          cap_wdata = bus_wdata;
        end
        len++;
        oe_all &= (bus_wdata_oe === 1'b1);
        oe_any |= (bus_wdata_oe !== 1'b0);
      end else if (in_pulse) begin
        in_pulse = 1'b0;
        n_pulses++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL unexpected_pulse: got addr=%h rw=%b, required no pulse", cap_addr, cap_rw);
        end else begin
          cur = exp_q.pop_front();
          n_checks++;
          if (cap_addr !== cur.addr)
            $display("FAIL bus_addr: got %h, required %h", cap_addr, cur.addr);
          else n_pass++;
          n_checks++;
          if (cap_rw !== cur.rw) $display("FAIL bus_rw: got %b, required %b", cap_rw, cur.rw);
          else n_pass++;
          if (!cur.rw) begin
            n_checks++;
            if (cap_wdata !== cur.wdata)
              $display("FAIL bus_wdata: got %h, required %h", cap_wdata, cur.wdata);
            else n_pass++;
            n_checks++;
            if (!oe_all) $display("FAIL oe_during_write: got oe dropped, required high");
            else n_pass++;
            if (cur.full) begin
              n_checks++;
              if (bus_wdata_oe !== 1'b1)
                $display("FAIL oe_hold: got %b after sel rise, required 1", bus_wdata_oe);
              else n_pass++;
            end
          end else begin
            n_checks++;
            if (oe_any) $display("FAIL oe_during_read: got oe high, required low");
            else n_pass++;
          end
          if (cur.full) begin
            n_checks++;
            if (len !== SelTicks) $display("FAIL sel_len: got %0d, required %0d", len, SelTicks);
            else n_pass++;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic spi_byte(input logic [7:0] mo, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi = mo[i];
      #(Half);
      spi_sck = 1'b1;
      mi[i]   = spi_miso;
      #(Half);
      spi_sck = 1'b0;
    end
  endtask

  task automatic send_frame(input logic [7:0] b0, b1, b2, input int gap, output logic [7:0] r2);
    logic [7:0] dummy;
    spi_ss_n = 1'b0;
    spi_byte(b0, dummy);
    spi_byte(b1, dummy);
    #(gap);
    spi_byte(b2, r2);
    spi_ss_n = 1'b1;
  endtask

  task automatic wait_drain(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock_50);
      if (exp_q.size() == 0 && bus_sel_n === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0; spi_sck = 1'b0; spi_ss_n = 1'b1; spi_mosi = 1'b0; bus_rdata = 8'h00;
    repeat (3) @(negedge clock_50);
    n_checks++; if (bus_sel_n !== 1'b1) $display("FAIL rst_sel_n: got %b, required 1", bus_sel_n); else n_pass++;
    n_checks++; if (bus_rw !== 1'b1) $display("FAIL rst_rw: got %b, required 1", bus_rw); else n_pass++;
    n_checks++; if (bus_wdata_oe !== 1'b0) $display("FAIL rst_oe: got %b, required 0", bus_wdata_oe); else n_pass++;
    n_checks++; if (bus_addr !== 16'h0000) $display("FAIL rst_addr: got %h, required 0000", bus_addr); else n_pass++;
    n_checks++; if (bus_wdata !== 8'h00) $display("FAIL rst_wdata: got %h, required 00", bus_wdata); else n_pass++;
    n_checks++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err: got %b, required 0", frame_err); else n_pass++;
    reset_n = 1'b1;
    repeat (4) @(negedge clock_50);
  endtask

  task automatic test_write;
    logic [7:0] r;
    bit ok;
    int fe0 = fe_samples;
    exp_q.push_back('{addr: 16'h7F49, rw: 1'b0, wdata: 8'h5A, full: 1'b1});
    @(negedge clock_50);
    send_frame(8'h7F, 8'h49, 8'h5A, 0, r);
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL write_drain: got pending=%0d, required 0", exp_q.size()); else n_pass++;
    repeat (2) @(negedge clock_50);
    n_checks++; if (bus_wdata_oe !== 1'b0) $display("FAIL write_oe_off: got %b, required 0", bus_wdata_oe); else n_pass++;
    n_checks++; if (fe_samples - fe0 !== 0) $display("FAIL write_no_err: got %0d, required 0", fe_samples - fe0); else n_pass++;
  endtask

  task automatic test_read(input logic [7:0] b0, b1, rd, input logic [15:0] ea, input string nm);
    logic [7:0] r;
    bit ok;
    int fe0 = fe_samples;
    bus_rdata = rd;
    exp_q.push_back('{addr: ea, rw: 1'b1, wdata: 8'h00, full: 1'b1});
    @(negedge clock_50);
    send_frame(b0, b1, 8'h00, 2000, r);
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL %s_drain: got pending=%0d, required 0", nm, exp_q.size()); else n_pass++;
    n_checks++; if (r !== rd) $display("FAIL %s_miso: got %h, required %h", nm, r, rd); else n_pass++;
    repeat (10) @(negedge clock_50);
    n_checks++; if (fe_samples - fe0 !== 0) $display("FAIL %s_no_err: got %0d, required 0", nm, fe_samples - fe0); else n_pass++;
  endtask

  task automatic test_abort;
    logic [7:0] r;
    int fe0 = fe_samples, p0 = n_pulses;
    @(negedge clock_50);
    spi_ss_n = 1'b0;
    spi_byte(8'h12, r);
    spi_byte(8'h34, r);
    spi_ss_n = 1'b1;
    repeat (30) @(negedge clock_50);
    n_checks++; if (fe_samples - fe0 !== 1) $display("FAIL abort_err_pulse: got %0d cycles, required 1", fe_samples - fe0); else n_pass++;
    n_checks++; if (n_pulses - p0 !== 0) $display("FAIL abort_no_sel: got %0d pulses, required 0", n_pulses - p0); else n_pass++;
  endtask

  task automatic test_reset_mid_write;
    logic [7:0] r;
    bit ok, seen = 1'b0;
    exp_q.push_back('{addr: 16'h1234, rw: 1'b0, wdata: 8'h77, full: 1'b0});
    @(negedge clock_50);
    spi_ss_n = 1'b0;
    spi_byte(8'h12, r);
    spi_byte(8'h34, r);
    spi_byte(8'h77, r);
    for (int c = 0; c < 50; c++) begin
      if (bus_sel_n === 1'b0) begin seen = 1'b1; break; end
      @(negedge clock_50);
    end
    n_checks++; if (!seen) $display("FAIL midwr_sel_seen: got no strobe, required strobe"); else n_pass++;
    repeat (2) @(negedge clock_50);
    #5 reset_n = 1'b0;
    #1;
    n_checks++; if (bus_sel_n !== 1'b1) $display("FAIL midwr_sel_n: got %b, required 1", bus_sel_n); else n_pass++;
    n_checks++; if (bus_wdata_oe !== 1'b0) $display("FAIL midwr_oe: got %b, required 0", bus_wdata_oe); else n_pass++;
    spi_ss_n = 1'b1;
    repeat (3) @(negedge clock_50);
    reset_n = 1'b1;
    repeat (4) @(negedge clock_50);
    exp_q.push_back('{addr: 16'h0155, rw: 1'b0, wdata: 8'hC3, full: 1'b1});
    send_frame(8'h01, 8'h55, 8'hC3, 0, r);
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL midwr_recover: got pending=%0d, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_back_to_back;
    logic [7:0] r;
    bit ok;
    int p0 = n_pulses;
    exp_q.push_back('{addr: 16'h2ABC, rw: 1'b0, wdata: 8'h11, full: 1'b1});
    exp_q.push_back('{addr: 16'h0506, rw: 1'b0, wdata: 8'hEE, full: 1'b1});
    @(negedge clock_50);
    send_frame(8'h2A, 8'hBC, 8'h11, 0, r);
    #80;
    send_frame(8'h05, 8'h06, 8'hEE, 0, r);
    wait_drain(ok);
    n_checks++; if (!ok) $display("FAIL b2b_drain: got pending=%0d, required 0", exp_q.size()); else n_pass++;
    n_checks++; if (n_pulses - p0 !== 2) $display("FAIL b2b_pulses: got %0d, required 2", n_pulses - p0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read(8'hFF, 8'h48, 8'hA5, 16'h7F48, "read_a5");
    test_read(8'h80, 8'h10, 8'h3C, 16'h0010, "read_flash");
    test_abort();
    test_reset_mid_write();
    test_back_to_back();
    repeat (10) @(negedge clock_50);
    n_checks++; if (n_pulses !== 7) $display("FAIL total_pulses: got %0d, required 7", n_pulses); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
